// File: rtl/cpu_pkg.sv
// Shared CPU definitions: cpustate encodings and default memory geometry.
package cpu_pkg;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'b00,
    CS_IN    = 2'b01,
    CS_CHECK = 2'b10,
    CS_RUN   = 2'b11
  } cpustate_t;

  localparam int unsigned DEFAULT_DEPTH = 256;
  localparam int unsigned DATA_W        = 8;

endpackage

// File: rtl/mem_array.sv
// DEPTH x 8 storage: one synchronous write port, two combinational read ports.
// Ports:
//   clk                          write clock
//   we / waddr / wdata           write port (muxed by the parent)
//   cpu_raddr / cpu_rdata_c      CPU read port
//   chk_raddr / chk_rdata_c      check-mode read port
module mem_array
  import cpu_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     cpu_raddr,
  output logic [DATA_W-1:0] cpu_rdata_c,
  input  logic [AW-1:0]     chk_raddr,
  output logic [DATA_W-1:0] chk_rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign cpu_rdata_c = mem[cpu_raddr];
  assign chk_rdata_c = mem[chk_raddr];

endmodule

// File: rtl/mem_responder.sv
// CPU-side memory responder: RUN-mode read/write, IN-mode program byte
// loading, CHECK-mode registered readback.
// Optional feature macro: MEM_RESPONDER_CHECKSUM_EN (XOR checksum on ld_sum;
// when undefined ld_sum is tied to zero).
// Ports:
//   clk, reset (async, active-low)
//   cpustate            CPU mode (IDLE/IN/CHECK/RUN)
//   addr, read, write   CPU address and strobes (RUN only; low AW bits used)
//   bus_in              write data; mem_out/mem_oe read data and drive enable
//   in_valid/in_data/in_ready   program-load byte stream (IN only)
//   chk_addr/chk_data   CHECK-mode readback, one-cycle latency
//   ld_count/ld_wrap/ld_sum     load statistics since last IN entry
module mem_responder
  import cpu_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cpustate,
  input  logic [15:0]       addr,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] mem_out,
  output logic              mem_oe,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [AW-1:0]     chk_addr,
  output logic [DATA_W-1:0] chk_data,
  output logic [AW:0]       ld_count,
  output logic              ld_wrap,
  output logic [DATA_W-1:0] ld_sum
);

  localparam int unsigned   CW       = AW + 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  cpustate_t         mode_c;
  cpustate_t         prev_state;
  cpustate_t         prev_state_nxt;
  logic              in_entry_c;
  logic              accept_c;
  logic [AW-1:0]     ld_ptr;
  logic [AW-1:0]     ld_ptr_nxt;
  logic [AW-1:0]     ptr_base_c;
  logic [CW-1:0]     ld_count_nxt;
  logic [CW-1:0]     count_base_c;
  logic              ld_wrap_nxt;
  logic              mem_we_c;
  logic [AW-1:0]     mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] cpu_rdata_c;
  logic [DATA_W-1:0] chk_rdata_c;
  logic              unused_addr_hi;

  assign mode_c         = cpustate_t'(cpustate);
  assign unused_addr_hi = ^addr[15:AW];

  // Mode tracker state register: previous cpustate, for IN-entry detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_state <= CS_IDLE;
    end else begin
      prev_state <= prev_state_nxt;
    end
  end

  // Next-state, load bookkeeping, write-port mux and CPU bus outputs.
  always_comb begin
    prev_state_nxt = prev_state;
    in_entry_c     = 1'b0;
    accept_c       = 1'b0;
    ptr_base_c     = ld_ptr;
    count_base_c   = ld_count;
    ld_ptr_nxt     = ld_ptr;
    ld_count_nxt   = ld_count;
    ld_wrap_nxt    = ld_wrap;
    mem_we_c       = 1'b0;
    mem_waddr_c    = '0;
    mem_wdata_c    = '0;
    mem_oe         = 1'b0;
    mem_out        = '0;
    in_ready       = 1'b0;

    prev_state_nxt = mode_c;
    in_entry_c     = (mode_c == CS_IN) && (prev_state != CS_IN);
    in_ready       = reset && (mode_c == CS_IN);
    accept_c       = in_ready && in_valid;

    // Entering IN restarts the load as if the counters were already clear,
    // so a byte accepted on the entry cycle lands at address 0.
    if (in_entry_c) begin
      ptr_base_c   = '0;
      count_base_c = '0;
      ld_wrap_nxt  = 1'b0;
    end
    ld_ptr_nxt   = ptr_base_c;
    ld_count_nxt = count_base_c;

    if (accept_c) begin
      ld_ptr_nxt  = ptr_base_c + AW'(1);
      mem_we_c    = 1'b1;
      mem_waddr_c = ptr_base_c;
      mem_wdata_c = in_data;
      if (count_base_c != CNT_MAX) begin
        ld_count_nxt = count_base_c + CW'(1);
      end
      if (ptr_base_c == PTR_LAST) begin
        ld_wrap_nxt = 1'b1;
      end
    end

    // RUN: write wins over read; read data only driven for a pure read.
    if (reset && (mode_c == CS_RUN)) begin
      if (write) begin
        mem_we_c    = 1'b1;
        mem_waddr_c = addr[AW-1:0];
        mem_wdata_c = bus_in;
      end else if (read) begin
        mem_oe  = 1'b1;
        mem_out = cpu_rdata_c;
      end
    end
  end

  // Load counters and check-mode readback register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_ptr   <= '0;
      ld_count <= '0;
      ld_wrap  <= 1'b0;
      chk_data <= '0;
    end else begin
      ld_ptr   <= ld_ptr_nxt;
      ld_count <= ld_count_nxt;
      ld_wrap  <= ld_wrap_nxt;
      if (mode_c == CS_CHECK) begin
        chk_data <= chk_rdata_c;
      end
    end
  end

`ifdef MEM_RESPONDER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // Running XOR of accepted bytes since the most recent IN entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (in_entry_c) begin
      sum_q <= accept_c ? in_data : '0;
    end else if (accept_c) begin
      sum_q <= sum_q ^ in_data;
    end
  end

  assign ld_sum = sum_q;
`else
  assign ld_sum = '0;
`endif

  mem_array #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk         (clk),
    .we          (mem_we_c),
    .waddr       (mem_waddr_c),
    .wdata       (mem_wdata_c),
    .cpu_raddr   (addr[AW-1:0]),
    .cpu_rdata_c (cpu_rdata_c),
    .chk_raddr   (chk_addr),
    .chk_rdata_c (chk_rdata_c)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the stimulus process predicts each
// cycle's outputs from a behavioural memory model and queues them; the
// monitor compares DUT outputs against the queue at every falling edge.
module tb_mem_responder;
  import cpu_pkg::*;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    cpustate = 2'b00;
  logic [15:0]   addr = '0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [7:0]    bus_in = '0;
  logic [7:0]    mem_out;
  logic          mem_oe;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic [AW-1:0] chk_addr = '0;
  logic [7:0]    chk_data;
  logic [AW:0]   ld_count;
  logic          ld_wrap;
  logic [7:0]    ld_sum;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpustate (cpustate),
    .addr     (addr),
    .read     (read),
    .write    (write),
    .bus_in   (bus_in),
    .mem_out  (mem_out),
    .mem_oe   (mem_oe),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .chk_addr (chk_addr),
    .chk_data (chk_data),
    .ld_count (ld_count),
    .ld_wrap  (ld_wrap),
    .ld_sum   (ld_sum)
  );

  typedef struct {
    string    tag;
    bit       oe;
    int       out;
    bit       out_known;
    bit       rdy;
    int       chk;
    bit       chk_known;
    int       cnt;
    bit       wrap;
    int       sum;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model state
  int        m_mem [DEPTH];
  bit        m_known [DEPTH];
  int        m_ptr, m_cnt, m_sum, m_chk;
  bit        m_wrap, m_chk_known;
  cpustate_t m_prev;

  function automatic void model_reset();
    m_ptr = 0; m_cnt = 0; m_sum = 0; m_chk = 0;
    m_wrap = 1'b0; m_chk_known = 1'b1; m_prev = CS_IDLE;
  endfunction

  function automatic void cmp(string tag, string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s/%s actual=0x%0h required=0x%0h t=%0t", tag, name, act, req, $time);
    end
  endfunction

  // Drive one cycle, queue its expected outputs, then advance the model.
  task automatic step(input string tag, input bit rst, input cpustate_t cs,
                      input logic [15:0] a, input bit rd, input bit wr,
                      input logic [7:0] bus, input bit iv, input logic [7:0] idat,
                      input logic [7:0] ca);
    exp_t e;
    int   ai;
    reset = rst; cpustate = cs; addr = a; read = rd; write = wr;
    bus_in = bus; in_valid = iv; in_data = idat; chk_addr = ca;
    if (!rst) model_reset();
    ai = int'(a) % DEPTH;
    e.tag       = tag;
    e.oe        = rst && (cs == CS_RUN) && rd && !wr;
    e.out       = e.oe ? m_mem[ai] : 0;
    e.out_known = !e.oe || m_known[ai];
    e.rdy       = rst && (cs == CS_IN);
    e.chk       = m_chk;
    e.chk_known = m_chk_known;
    e.cnt       = m_cnt;
    e.wrap      = m_wrap;
    e.sum       = m_sum;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (rst) begin
      if (cs == CS_IN && m_prev != CS_IN) begin
        m_ptr = 0; m_cnt = 0; m_wrap = 1'b0; m_sum = 0;
      end
      if (cs == CS_CHECK) begin
        m_chk = m_mem[int'(ca)]; m_chk_known = m_known[int'(ca)];
      end
      if (cs == CS_IN && iv) begin
        m_mem[m_ptr] = int'(idat); m_known[m_ptr] = 1'b1;
        if (m_ptr == DEPTH - 1) m_wrap = 1'b1;
        m_ptr = (m_ptr + 1) % DEPTH;
        if (m_cnt < DEPTH) m_cnt++;
`ifdef MEM_RESPONDER_CHECKSUM_EN
        m_sum = m_sum ^ int'(idat);
`endif
      end
      if (cs == CS_RUN && wr) begin
        m_mem[ai] = int'(bus); m_known[ai] = 1'b1;
      end
      m_prev = cs;
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b1, CS_IDLE, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 8'h0, 8'h0);
  endtask

  task automatic load(input string tag, input logic [7:0] d);
    step(tag, 1'b1, CS_IN, 16'h0, 1'b0, 1'b0, 8'h0, 1'b1, d, 8'h0);
  endtask

  task automatic chk(input string tag, input logic [7:0] ca);
    step(tag, 1'b1, CS_CHECK, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 8'h0, ca);
  endtask

  task automatic run(input string tag, input logic [15:0] a, input bit rd, input bit wr,
                     input logic [7:0] bus);
    step(tag, 1'b1, CS_RUN, a, rd, wr, bus, 1'b0, 8'h0, 8'h0);
  endtask

  // Monitor: one queued expectation per cycle, compared mid-cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.tag, "mem_oe", int'(mem_oe), int'(e.oe));
        if (e.out_known) cmp(e.tag, "mem_out", int'(mem_out), e.out);
        cmp(e.tag, "in_ready", int'(in_ready), int'(e.rdy));
        if (e.chk_known) cmp(e.tag, "chk_data", int'(chk_data), e.chk);
        cmp(e.tag, "ld_count", int'(ld_count), e.cnt);
        cmp(e.tag, "ld_wrap", int'(ld_wrap), int'(e.wrap));
        cmp(e.tag, "ld_sum", int'(ld_sum), e.sum);
      end
    end
  end

  initial begin : stimulus
    cpustate_t cs;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 0; m_known[i] = 1'b0;
    end
    model_reset();
    @(posedge clk);
    #1;

    repeat (3) step("reset", 1'b0, CS_IDLE, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 8'h0, 8'h0);
    idle("post_reset");

    // Short program load followed by readback
    load("in_11", 8'h11);
    load("in_22", 8'h22);
    load("in_33", 8'h33);
    step("in_hold", 1'b1, CS_IN, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 8'h0, 8'h0);
    idle("in_done");
    chk("chk_1", 8'd1);
    idle("chk_1_res");
    chk("chk_0", 8'd0);
    chk("chk_2", 8'd2);
    idle("chk_2_res");

    // RUN: aliased write/read, and write-wins on simultaneous strobes
    run("run_wr_alias", 16'h0105, 1'b0, 1'b1, 8'hA5);
    run("run_rd_alias", 16'h0005, 1'b1, 1'b0, 8'h00);
    run("run_rw", 16'h0002, 1'b1, 1'b1, 8'h5A);
    run("run_rd2", 16'h0002, 1'b1, 1'b0, 8'h00);
    run("run_nostrobe", 16'h0002, 1'b0, 1'b0, 8'h00);
    step("idle_rw_ignored", 1'b1, CS_IDLE, 16'h0002, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h0, 8'h0);
    run("run_rd3", 16'h0002, 1'b1, 1'b0, 8'h00);

    // Full load of DEPTH+1 bytes: wraps, saturates, last byte at address 0
    idle("pre_wrap");
    for (int i = 0; i <= DEPTH; i++) load("wrap_load", 8'($urandom));
    idle("wrap_done");
    chk("wrap_chk0", 8'd0);
    chk("wrap_chk255", 8'd255);
    idle("wrap_chk_res");

    // Reset mid-load: bytes kept, re-entry restarts at address 0
    load("mid_aa", 8'hAA);
    idle("mid_gap");
    load("mid_b0", 8'hB0);
    load("mid_b1", 8'hB1);
    step("mid_reset", 1'b0, CS_IN, 16'h0, 1'b0, 1'b0, 8'h0, 1'b1, 8'hEE, 8'h0);
    idle("mid_release");
    chk("mid_chk0", 8'd0);
    chk("mid_chk1", 8'd1);
    idle("mid_chk_res");
    load("reentry_cc", 8'hCC);
    idle("reentry_done");
    chk("reentry_chk0", 8'd0);
    chk("reentry_chk1", 8'd1);
    idle("reentry_res");

    // Randomized traffic with sticky modes and occasional reset
    cs = CS_RUN;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(7) == 0) cs = cpustate_t'(2'($urandom));
      step("rand", ($urandom_range(299) != 0), cs, 16'($urandom),
           1'($urandom), ($urandom_range(3) == 0), 8'($urandom),
           1'($urandom), 8'($urandom), 8'($urandom));
    end
    idle("final");

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
